// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: default geometry, stage-count helper and the
// control tag that travels down the adder pipeline with each operation.
package arith_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CHUNK = 4;

  function automatic int stages(input int width, input int chunk);
    return width / chunk;
  endfunction

  typedef struct packed {
    logic valid;
    logic sub;
    logic is_signed;
  } tag_t;

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result bus of the pipelined adder; master drives operations, slave
// (the adder) returns results.
interface pipelined_adder_if #(
  parameter int WIDTH = arith_pkg::DEFAULT_WIDTH
);
  logic             en;
  logic             valid_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             is_signed;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             valid_out;

  modport master (
    output en, valid_in, a, b, cin, sub, is_signed,
    input  sum, cout, overflow, valid_out
  );

  modport slave (
    input  en, valid_in, a, b, cin, sub, is_signed,
    output sum, cout, overflow, valid_out
  );
endinterface

// File: rtl/adder_stage.sv
// One CHUNK-bit slice of the carry-pipelined adder: registered sum, carry out
// and carry into the slice MSB.
module adder_stage
  import arith_pkg::*;
#(
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum   <= '0;
      cout  <= 1'b0;
      c_msb <= 1'b0;
    end else if (en) begin
      sum   <= full[CHUNK-1:0];
      cout  <= full[CHUNK];
      // The MSB sum bit is a^b^carry_in, so the carry into it falls out by XOR.
      c_msb <= full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// Carry-pipelined WIDTH-bit add/subtract unit: one CHUNK-bit slice per stage,
// input skew and output de-skew registers keep every chunk of an operation aligned.
module pipelined_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic               clk,
  input  logic               rst,
  pipelined_adder_if.slave   bus
);

  localparam int STAGES = stages(WIDTH, CHUNK);

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_geometry
      $error("pipelined_adder: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  logic [WIDTH-1:0] b_eff;
  tag_t             tag_in;
  tag_t             tag_reg    [STAGES];
  logic             slot_valid [STAGES];
  logic             carry      [STAGES];
  logic [CHUNK-1:0] stage_sum  [STAGES];
  logic             top_c_msb;
  logic [WIDTH-1:0] sum_aligned;
  tag_t             tag_out;

  assign b_eff  = bus.sub ? ~bus.b : bus.b;
  assign tag_in = '{valid: bus.valid_in, sub: bus.sub, is_signed: bus.is_signed};

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      tag_t             tag_src;
      logic [CHUNK-1:0] op_a;
      logic [CHUNK-1:0] op_b;
      logic             op_cin;
      logic             c_msb;

      // slot_valid[k] is the tag of the operation that stage k consumes this cycle.
      if (gi == 0) begin : g_head
        assign tag_src = tag_in;
        assign op_a    = bus.a[CHUNK-1:0];
        assign op_b    = b_eff[CHUNK-1:0];
        assign op_cin  = bus.sub ? 1'b1 : bus.cin;
      end else begin : g_body
        logic [CHUNK-1:0] a_sh [gi];
        logic [CHUNK-1:0] b_sh [gi];

        assign tag_src = tag_reg[gi-1];
        assign op_a    = a_sh[gi-1];
        assign op_b    = b_sh[gi-1];
        assign op_cin  = carry[gi-1];

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            for (int j = 0; j < gi; j++) begin
              a_sh[j] <= '0;
              b_sh[j] <= '0;
            end
          end else if (bus.en) begin
            if (slot_valid[0]) begin
              a_sh[0] <= bus.a[gi*CHUNK +: CHUNK];
              b_sh[0] <= b_eff[gi*CHUNK +: CHUNK];
            end
            for (int j = 1; j < gi; j++) begin
              if (slot_valid[j]) begin
                a_sh[j] <= a_sh[j-1];
                b_sh[j] <= b_sh[j-1];
              end
            end
          end
        end
      end

      assign slot_valid[gi] = tag_src.valid;

      // Sub/signed only advance with real operations so the overflow of the
      // last result stays put while bubbles pass.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          tag_reg[gi] <= '0;
        end else if (bus.en) begin
          tag_reg[gi].valid <= tag_src.valid;
          if (tag_src.valid) begin
            tag_reg[gi].sub       <= tag_src.sub;
            tag_reg[gi].is_signed <= tag_src.is_signed;
          end
        end
      end

      adder_stage #(.CHUNK(CHUNK)) u_stage (
        .clk   (clk),
        .rst   (rst),
        .en    (bus.en & slot_valid[gi]),
        .a     (op_a),
        .b     (op_b),
        .cin   (op_cin),
        .sum   (stage_sum[gi]),
        .cout  (carry[gi]),
        .c_msb (c_msb)
      );

      if (gi == STAGES - 1) begin : g_top
        assign top_c_msb = c_msb;
        assign sum_aligned[gi*CHUNK +: CHUNK] = stage_sum[gi];
      end else begin : g_deskew
        localparam int DEPTH = STAGES - 1 - gi;
        logic [CHUNK-1:0] ds [DEPTH];
        logic             msb_unused;

        assign msb_unused = c_msb;
        assign sum_aligned[gi*CHUNK +: CHUNK] = ds[DEPTH-1];

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            for (int m = 0; m < DEPTH; m++) begin
              ds[m] <= '0;
            end
          end else if (bus.en) begin
            if (slot_valid[gi+1]) begin
              ds[0] <= stage_sum[gi];
            end
            for (int m = 1; m < DEPTH; m++) begin
              if (slot_valid[gi+1+m]) begin
                ds[m] <= ds[m-1];
              end
            end
          end
        end
      end
    end
  endgenerate

  assign tag_out       = tag_reg[STAGES-1];
  assign bus.sum       = sum_aligned;
  assign bus.cout      = carry[STAGES-1];
  assign bus.valid_out = tag_out.valid;

  always_comb begin
    bus.overflow = carry[STAGES-1];
    if (tag_out.is_signed) begin
      bus.overflow = top_c_msb ^ carry[STAGES-1];
    end else if (tag_out.sub) begin
      bus.overflow = ~carry[STAGES-1];
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed scoreboard bench for the 16-bit, 4-stage pipelined adder.
module tb_pipelined_adder;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int STAGES = WIDTH / CHUNK;

  typedef struct {
    logic             v;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  exp_t             sb[$];
  logic [WIDTH-1:0] last_sum;
  logic             last_cout;
  logic             last_ovf;

  pipelined_adder_if #(.WIDTH(WIDTH)) bus ();

  pipelined_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub, input logic sgn);
    exp_t           e;
    logic [WIDTH:0] full;
    logic [WIDTH-1:0] bo;
    bo   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bo} + {{WIDTH{1'b0}}, (sub ? 1'b1 : cin)};
    e.v  = v;
    e.s  = full[WIDTH-1:0];
    e.c  = full[WIDTH];
    if (sgn)
      e.o = (a[WIDTH-1] == bo[WIDTH-1]) && (e.s[WIDTH-1] != a[WIDTH-1]);
    else
      e.o = sub ? ~e.c : e.c;
    return e;
  endfunction

  task automatic model_reset();
    exp_t bubble;
    bubble = '{v: 1'b0, s: '0, c: 1'b0, o: 1'b0};
    sb.delete();
    for (int i = 0; i < STAGES - 1; i++) sb.push_back(bubble);
    last_sum  = '0;
    last_cout = 1'b0;
    last_ovf  = 1'b0;
  endtask

  task automatic step(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic sub, input logic sgn);
    exp_t got;
    bus.en        = 1'b1;
    bus.valid_in  = v;
    bus.a         = a;
    bus.b         = b;
    bus.cin       = cin;
    bus.sub       = sub;
    bus.is_signed = sgn;
    sb.push_back(model(v, a, b, cin, sub, sgn));
    @(posedge clk);
    #1;
    got = sb.pop_front();
    $display("step v=%0b a=%h b=%h cin=%0b sub=%0b sgn=%0b -> vout=%0b sum=%h cout=%0b ovf=%0b",
             v, a, b, cin, sub, sgn, bus.valid_out, bus.sum, bus.cout, bus.overflow);
    check("valid_out", bus.valid_out, got.v);
    if (got.v) begin
      check("sum", bus.sum, got.s);
      check("cout", bus.cout, got.c);
      check("overflow", bus.overflow, got.o);
      last_sum  = got.s;
      last_cout = got.c;
      last_ovf  = got.o;
    end else begin
      check("hold_sum", bus.sum, last_sum);
      check("hold_ovf", bus.overflow, last_ovf);
    end
  endtask

  task automatic bubble_step();
    step(1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic idle_step();
    logic [WIDTH-1:0] s0;
    logic             v0, c0, o0;
    s0 = bus.sum; v0 = bus.valid_out; c0 = bus.cout; o0 = bus.overflow;
    bus.en       = 1'b0;
    bus.valid_in = 1'b1;
    bus.a        = WIDTH'($urandom);
    bus.b        = WIDTH'($urandom);
    @(posedge clk);
    #1;
    $display("idle en=0 -> vout=%0b sum=%h cout=%0b ovf=%0b", bus.valid_out, bus.sum, bus.cout, bus.overflow);
    check("freeze_sum", bus.sum, s0);
    check("freeze_vout", bus.valid_out, v0);
    check("freeze_cout", bus.cout, c0);
    check("freeze_ovf", bus.overflow, o0);
    bus.en = 1'b1;
  endtask

  initial begin
    bus.en = 1'b1; bus.valid_in = 1'b0; bus.a = '0; bus.b = '0;
    bus.cin = 1'b0; bus.sub = 1'b0; bus.is_signed = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_sum", bus.sum, 0);
    check("reset_cout", bus.cout, 0);
    check("reset_ovf", bus.overflow, 0);
    check("reset_vout", bus.valid_out, 0);
    rst = 1'b0;
    model_reset();

    // Directed corner vectors
    step(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h0003, 16'h0005, 1'b1, 1'b1, 1'b0);
    step(1'b1, 16'h0003, 16'h0005, 1'b1, 1'b1, 1'b1);
    step(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < STAGES; i++) bubble_step();

    // Back-to-back stream with a two-cycle enable gap
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, WIDTH'(i), WIDTH'(2 * i), 1'b0, 1'(i % 2 == 0), 1'(i % 3 == 0));
      if (i == 4) begin
        idle_step();
        idle_step();
      end
    end
    for (int i = 0; i < STAGES; i++) bubble_step();

    // Async reset with three operations in flight
    step(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < STAGES - 1; i++) bubble_step();
    step(1'b1, 16'hA000, 16'h0B00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0C0C, 16'h0101, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'h5555, 16'h5555, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    #2;
    $display("async reset -> vout=%0b sum=%h cout=%0b ovf=%0b", bus.valid_out, bus.sum, bus.cout, bus.overflow);
    check("async_rst_sum", bus.sum, 0);
    check("async_rst_vout", bus.valid_out, 0);
    check("async_rst_cout", bus.cout, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < STAGES; i++) bubble_step();

    // Valid pattern 1,0,1,1,0
    step(1'b1, 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b0);
    bubble_step();
    step(1'b1, 16'h4000, 16'h4000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h0010, 16'h0020, 1'b1, 1'b1, 1'b0);
    bubble_step();
    for (int i = 0; i < STAGES + 1; i++) bubble_step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the team's 4-bit adder. Supports any WIDTH, split into CHUNK-bit carry-pipelined stages.
- Adds add/subtract mode, signed/unsigned overflow selection, a clock enable and a valid flag that travels with each operation.
- Serves as the arithmetic building block for the datapath and for later ALU work.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per pipeline stage; STAGES = WIDTH/CHUNK; latency = STAGES enabled cycles.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- En  in  1  pipeline enable; 0 freezes every register.
- Valid_in  in  1  A/B/Cin/Sub/Signed hold an operation to accept.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Cin  in  1  carry in; ignored when Sub=1.
- Sub  in  1  1: A-B (computed as A+~B+1); 0: A+B+Cin.
- Signed  in  1  selects the overflow definition for this operation.
- Sum  out  WIDTH  registered result.
- Cout  out  1  carry out of the MSB; when Sub=1, Cout=1 means A>=B unsigned.
- Overflow  out  1  see overflow rules below.
- Valid_out  out  1  Sum/Cout/Overflow hold a result this cycle.

Behaviour:
- Reset (async, asserted): Sum=0, Cout=0, Overflow=0, Valid_out=0, and all internal stage, skew and valid registers cleared immediately, with no clock needed. In-flight operations are discarded. First acceptance is on the first rising Clk after Reset deasserts.
- Acceptance: on a rising Clk with En=1, the inputs are sampled, with Valid_in carried as a tag. Operations are accepted every enabled cycle; there is no backpressure.
- En=0: no register changes, including outputs and valid tags. Inputs are not sampled.
- Pipeline:
  - Stage k (0..STAGES-1) adds chunk k of A and of B' (B' = Sub ? ~B : B) plus the registered carry from stage k-1.
  - The stage-0 carry-in is Sub ? 1 : Cin.
  - Upper operand chunks are delayed through input skew registers. Lower result chunks are delayed through output de-skew registers so all chunks align.
- Latency: a result accepted at enabled edge n appears on the outputs after enabled edge n+STAGES-1, i.e. it is visible for the cycle following the STAGES-th enabled edge including acceptance. With En held at 1, a 4-stage config shows the result 4 cycles after sampling.
- Throughput and ordering: one result per enabled cycle; strict in-order; Valid_out follows the Valid_in tag exactly.
- Valid_in=0 slots: travel through the pipeline as bubbles. Data registers may update, but Valid_out=0 for that slot.
- Overflow, evaluated per operation using that operation's own Sub/Signed (both are pipelined alongside the data):
  - Signed=1: Overflow = carry into MSB XOR carry out of MSB.
  - Signed=0, Sub=0: Overflow = Cout.
  - Signed=0, Sub=1: Overflow = ~Cout (borrow).
- Wrap-around: Sum is always the low WIDTH bits of the result (modulo 2^WIDTH); saturation is not performed.
- Outputs hold their last value while Valid_out=0 and while En=0.
- WIDTH==CHUNK degenerates to one stage with latency 1.
- Illegal WIDTH % CHUNK != 0: elaboration-time error.

Decomposition:
- Shared package arith_pkg:
  - Default WIDTH/CHUNK constants.
  - A function stages(WIDTH, CHUNK) returning the stage count.
  - A packed struct holding the pipelined control tag: valid, sub, signed.
- One sub-module, adder_stage: a CHUNK-bit slice.
  - Inputs: chunk operands, carry in, En, Clk, Reset.
  - Outputs: registered chunk sum, registered carry out, registered carry into its MSB (used for signed overflow in the top stage only).
- The top level generates STAGES instances plus the skew and de-skew shift registers.

Test Plan (WIDTH=16, CHUNK=4, En=1 unless stated):
- Reset asserted between clock edges while 3 operations are in flight -> Sum=0x0000, Valid_out=0 immediately. Nothing emerges during the first 4 cycles after release.
- A=0x00FF, B=0x0001, Cin=0, Sub=0, Signed=0 -> 4 cycles later Sum=0x0100, Cout=0, Overflow=0, Valid_out=1 for one cycle. This checks carry ripple across chunks.
- A=0xFFFF, B=0x0001, Sub=0, Signed=0 -> Sum=0x0000, Cout=1, Overflow=1. Same inputs with Signed=1 -> Overflow=0.
- A=0x7FFF, B=0x0001, Signed=1 -> Sum=0x8000, Cout=0, Overflow=1. A=0x0003, B=0x0005, Sub=1, Cin=1 -> Sum=0xFFFE, Cout=0; Overflow=1 if Signed=0, 0 if Signed=1.
- 8 back-to-back vectors (A=i, B=2i, i=1..8, Sub alternating), with En forced 0 for 2 cycles mid-stream -> 8 results in order with correct values. Outputs are frozen during En=0, and total latency is extended by exactly 2 cycles.
- Valid_in pattern 1,0,1,1,0 -> Valid_out shows 1,0,1,1,0 starting 4 cycles later. Sum is unchanged during the Valid_out=0 cycles.
